// File: rtl/v2f_link_rx_pkg.sv
// Shared types, header layout and helpers for the v2f wire-link receiver.
package v2f_link_pkg;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DROP} state_e;

  localparam int LEN_LSB   = 0;
  localparam int LEN_MSB   = 7;
  localparam int MAGIC_LSB = 8;

  localparam logic [23:0] MAGIC_DEFAULT = 24'hF0C7A1;

  // One FIFO entry: payload word plus end-of-frame marker.
  typedef struct packed {
    logic        last;
    logic [31:0] dat;
  } meta_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/v2f_link_rx_if.sv
// Link-side word input and valid/ready output of the receiver.
// master = link source + consumer; slave = the receiver.
interface v2f_link_rx_if;
  logic        link_valid;
  logic [31:0] link_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output link_valid, link_data, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  link_valid, link_data, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/v2f_link_rx_fifo.sv
// Store-and-forward FIFO with speculative write pointer: commit publishes, rollback discards.
// Read data is combinational at rd; reads only ever see committed entries.
module v2f_link_fifo
  import v2f_link_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write,
  input  meta_t                  wr_dat,
  input  logic                   commit,
  input  logic                   rollback,
  input  logic                   read,
  output meta_t                  rd_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  meta_t         mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_spec_q, wr_spec_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;

  assign empty  = (rd_q == wr_commit_q);
  assign rd_dat = mem_q[rd_q[AW-1:0]];
  assign free   = PW'(DEPTH) - (wr_spec_q - rd_q);

  always_comb begin
    rd_d        = rd_q;
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    if (read && !empty) rd_d = rd_q + PW'(1);
    if (rollback)       wr_spec_d = wr_commit_q;
    else if (write)     wr_spec_d = wr_spec_q + PW'(1);
    if (commit)         wr_commit_d = wr_spec_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= '0;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
    end else begin
      rd_q        <= rd_d;
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
    end
    if (write) mem_q[wr_spec_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/v2f_link_rx.sv
// Frame parser for the no-backpressure word link; only checksum-good frames reach the consumer.
// First word shows on out_valid the cycle after the checksum word; consumer stalls never stall the link.
module v2f_link_rx
  import v2f_link_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter int          MAX_LEN = 8,
  parameter logic [23:0] MAGIC   = MAGIC_DEFAULT,
  parameter int          TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst,
  v2f_link_rx_if.slave  bus,
  output logic [15:0]   frames_ok,
  output logic [15:0]   frames_bad,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   sum_q, sum_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   ok_q, ok_d;
  logic [15:0]   bad_q, bad_d;
  logic          busy_q, busy_d;

  logic          fifo_write, fifo_commit, fifo_rollback, fifo_empty;
  meta_t         fifo_wr_dat, fifo_rd_dat;
  logic [PW-1:0] fifo_free;

  logic [7:0]    hdr_len;
  logic [23:0]   hdr_magic;
  logic          hdr_ok;
  logic [GW-1:0] gap_inc;
  logic          timeout;

  assign hdr_len   = bus.link_data[LEN_MSB:LEN_LSB];
  assign hdr_magic = bus.link_data[31:MAGIC_LSB];
  assign hdr_ok    = (hdr_magic == MAGIC) && (hdr_len != 8'd0) &&
                     ({24'd0, hdr_len} <= 32'(MAX_LEN));
  assign gap_inc   = gap_q + GW'(1);
  assign timeout   = (gap_inc == GW'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    gap_d         = gap_q;
    ok_d          = ok_q;
    bad_d         = bad_q;
    fifo_write    = 1'b0;
    fifo_wr_dat   = '0;
    fifo_commit   = 1'b0;
    fifo_rollback = 1'b0;

    if (state_q == IDLE) begin
      gap_d = '0;
      if (bus.link_valid) begin
        sum_d = '0;
        cnt_d = '0;
        if (!hdr_ok) begin
          bad_d = sat_inc(bad_q);
        end else begin
          len_d = hdr_len;
          // Space is reserved once, here; reads during the frame only add room.
          if (32'(fifo_free) >= 32'(hdr_len)) begin
            state_d = PAYLOAD;
          end else begin
            state_d = DROP;
            bad_d   = sat_inc(bad_q);
          end
        end
      end
    end else if (bus.link_valid) begin
      gap_d = '0;
      case (state_q)
        PAYLOAD: begin
          fifo_write       = 1'b1;
          fifo_wr_dat.dat  = bus.link_data;
          fifo_wr_dat.last = (cnt_q + 8'd1 == len_q);
          sum_d            = sum_q + bus.link_data;
          cnt_d            = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = CHECK;
        end
        CHECK: begin
          if (bus.link_data == sum_q) begin
            fifo_commit = 1'b1;
            ok_d        = sat_inc(ok_q);
          end else begin
            fifo_rollback = 1'b1;
            bad_d         = sat_inc(bad_q);
          end
          state_d = IDLE;
        end
        default: begin
          // DROP swallows len payload words plus the checksum.
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = IDLE;
        end
      endcase
    end else if (timeout) begin
      gap_d         = '0;
      fifo_rollback = 1'b1;
      if (state_q != DROP) bad_d = sat_inc(bad_q);
      state_d = IDLE;
    end else begin
      gap_d = gap_inc;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      gap_q   <= '0;
      ok_q    <= '0;
      bad_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      gap_q   <= gap_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
    end
  end

  v2f_link_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .write    (fifo_write),
    .wr_dat   (fifo_wr_dat),
    .commit   (fifo_commit),
    .rollback (fifo_rollback),
    .read     (bus.out_ready),
    .rd_dat   (fifo_rd_dat),
    .empty    (fifo_empty),
    .free     (fifo_free)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_rd_dat.dat;
  assign bus.out_last  = fifo_rd_dat.last;
  assign frames_ok     = ok_q;
  assign frames_bad    = bad_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_v2f_link_rx.sv
// Bench for v2f_link_rx: per-cycle vector table, directed corner sequences and random frames
// scored against a frame-level model (expected-word queue plus frame counters).
module tb_v2f_link_rx;

  localparam int DEPTH   = 16;
  localparam int MAX_LEN = 8;
  localparam int TIMEOUT = 32;
  localparam logic [31:0] HDR = 32'hF0C7A100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frames_ok, frames_bad;
  logic        busy;

  v2f_link_rx_if bus ();

  v2f_link_rx #(
    .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .MAGIC(24'hF0C7A1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .frames_ok(frames_ok), .frames_bad(frames_bad), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_chk, n_err, n_rd;
  int          m_ok, m_bad;
  int          rdy_mode;
  bit          rdy_fixed, mon_en;
  logic [32:0] exp_q[$];
  logic [31:0] pay[$];

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        e_busy;
    logic        e_ov;
    logic [31:0] e_dat;
    logic        e_last;
    logic [15:0] e_ok;
    logic [15:0] e_bad;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic b, input logic ov,
                              input logic [31:0] od, input logic ol, input logic [15:0] ok,
                              input logic [15:0] bad);
    vec_t r;
    r.vld = v; r.dat = d; r.e_busy = b; r.e_ov = ov;
    r.e_dat = od; r.e_last = ol; r.e_ok = ok; r.e_bad = bad;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    bus.link_valid = v;
    bus.link_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask

  // Frame-level model: header validity, admission against committed-unread words, checksum.
  task automatic send_frame(input logic [31:0] hdr, input bit corrupt, input int gap_max);
    int          len, free;
    bit          hv;
    logic [31:0] s;
    len  = int'(hdr[7:0]);
    hv   = (hdr[31:8] == 24'hF0C7A1) && (len >= 1) && (len <= MAX_LEN);
    free = DEPTH - exp_q.size();
    drive(1'b1, hdr);
    if (!hv) begin
      m_bad++;
      return;
    end
    if (free < len) begin
      m_bad++;
      for (int i = 0; i <= len; i++) begin
        idle($urandom_range(0, gap_max));
        drive(1'b1, $urandom);
      end
      return;
    end
    s = 32'd0;
    for (int i = 0; i < len; i++) begin
      idle($urandom_range(0, gap_max));
      s += pay[i];
      drive(1'b1, pay[i]);
    end
    idle($urandom_range(0, gap_max));
    if (corrupt) begin
      m_bad++;
      drive(1'b1, s + 32'd1);
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pay[i]});
      m_ok++;
      drive(1'b1, s);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      drive(1'b0, 32'd0);
      n++;
    end
    idle(2);
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_out_valid_idle"}, bus.out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rdy_mode  = 0;
    rdy_fixed = 1'b0;
    drive(1'b0, 32'd0);
    rst = 1'b1;
    drive(1'b0, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_ok  = 0;
    m_bad = 0;
  endtask

  // Consumer ready: fixed, alternating, or random.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = rdy_fixed;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (mon_en && !rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got %0h, expected no word", bus.out_data);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e[31:0]);
        chk("out_last", bus.out_last, e[32]);
      end
      n_rd++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int          n0, len, r;
    logic [31:0] hdr, k;
    n_chk = 0; n_err = 0; n_rd = 0; m_ok = 0; m_bad = 0;
    rdy_mode = 0; rdy_fixed = 1'b0; mon_en = 1'b0;
    rst = 1'b1;
    bus.link_valid = 1'b0;
    bus.link_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frames_ok", frames_ok, 16'd0);
    chk("rst_frames_bad", frames_bad, 16'd0);

    // Good 3-word frame, bad-checksum frame, then a good 1-word frame.
    tbl[0]  = mk(1, 32'hF0C7A103, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'd1,        1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 32'd2,        1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 32'd3,        1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 32'd6,        0, 1, 1, 0, 1, 0);
    tbl[5]  = mk(0, 32'd0,        0, 1, 2, 0, 1, 0);
    tbl[6]  = mk(0, 32'd0,        0, 1, 3, 1, 1, 0);
    tbl[7]  = mk(0, 32'd0,        0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 32'hF0C7A102, 1, 0, 0, 0, 1, 0);
    tbl[9]  = mk(1, 32'd5,        1, 0, 0, 0, 1, 0);
    tbl[10] = mk(1, 32'd5,        1, 0, 0, 0, 1, 0);
    tbl[11] = mk(1, 32'd11,       0, 0, 0, 0, 1, 1);
    tbl[12] = mk(1, 32'hF0C7A101, 1, 0, 0, 0, 1, 1);
    tbl[13] = mk(1, 32'd7,        1, 0, 0, 0, 1, 1);
    tbl[14] = mk(1, 32'd7,        0, 1, 7, 1, 2, 1);
    tbl[15] = mk(0, 32'd0,        0, 0, 0, 0, 2, 1);

    rdy_fixed = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].vld, tbl[i].dat);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].e_dat);
        chk($sformatf("tbl%0d_out_last", i), bus.out_last, tbl[i].e_last);
      end
      chk($sformatf("tbl%0d_frames_ok", i), frames_ok, tbl[i].e_ok);
      chk($sformatf("tbl%0d_frames_bad", i), frames_bad, tbl[i].e_bad);
    end

    // Overflow: two full frames fill the FIFO, a third is dropped.
    do_reset();
    mon_en = 1'b1;
    pay.delete(); for (int i = 0; i < 8; i++) pay.push_back(32'd100 + i);
    send_frame(HDR | 32'd8, 1'b0, 0);
    pay.delete(); for (int i = 0; i < 8; i++) pay.push_back(32'd200 + i);
    send_frame(HDR | 32'd8, 1'b0, 0);
    pay.delete(); pay.push_back(32'd9);
    send_frame(HDR | 32'd1, 1'b0, 0);
    chk("ovf_busy", busy, 1'b0);
    chk("ovf_frames_ok", frames_ok, 16'd2);
    chk("ovf_frames_bad", frames_bad, 16'd1);
    n0 = n_rd;
    rdy_fixed = 1'b1;
    drain("ovf");
    chk("ovf_words_read", n_rd - n0, 16);

    // Timeout mid-payload rolls back; the next frame arrives intact.
    do_reset();
    rdy_fixed = 1'b1;
    drive(1'b1, HDR | 32'd2);
    drive(1'b1, 32'hAA);
    idle(TIMEOUT - 1);
    chk("to_busy_before", busy, 1'b1);
    idle(1);
    chk("to_busy_after", busy, 1'b0);
    chk("to_frames_bad", frames_bad, 16'd1);
    chk("to_out_valid", bus.out_valid, 1'b0);
    pay.delete(); pay.push_back(32'd11); pay.push_back(32'd22);
    send_frame(HDR | 32'd2, 1'b0, 0);
    drain("to");
    chk("to_frames_ok", frames_ok, 16'd1);

    // Pointer wrap with alternating ready; payloads cross 32'hFFFFFFFF.
    do_reset();
    rdy_mode = 1;
    n0 = n_rd;
    for (int i = 0; i < 40; i++) begin
      k = 32'hFFFFFFF0 + 32'(i);
      pay.delete(); pay.push_back(k); pay.push_back(k + 32'd1); pay.push_back(k + 32'd2);
      send_frame(HDR | 32'd3, 1'b0, 0);
      idle(2);
    end
    drain("wrap");
    chk("wrap_frames_ok", frames_ok, 16'd40);
    chk("wrap_frames_bad", frames_bad, 16'd0);
    chk("wrap_words_read", n_rd - n0, 120);

    // Reset in the middle of a payload.
    do_reset();
    pay.delete(); pay.push_back(32'd1); pay.push_back(32'd2);
    send_frame(HDR | 32'd2, 1'b0, 0);
    drive(1'b1, HDR | 32'd4);
    drive(1'b1, 32'd3);
    drive(1'b1, 32'd4);
    chk("mrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    drive(1'b0, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_out_valid", bus.out_valid, 1'b0);
    chk("mrst_frames_ok", frames_ok, 16'd0);
    chk("mrst_frames_bad", frames_bad, 16'd0);
    chk("mrst_busy", busy, 1'b0);
    drive(1'b1, 32'd5);
    drive(1'b1, 32'd6);
    drive(1'b1, 32'd18);
    chk("mrst_tail_bad", frames_bad, 16'd3);
    chk("mrst_tail_busy", busy, 1'b0);
    chk("mrst_tail_out_valid", bus.out_valid, 1'b0);

    // Random frames, random ready, against the model.
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 200; f++) begin
      r   = $urandom_range(0, 99);
      len = $urandom_range(1, MAX_LEN);
      hdr = HDR | 32'(len);
      if (r < 5)       hdr = HDR;
      else if (r < 9)  hdr = HDR | 32'(MAX_LEN + 1);
      else if (r < 13) hdr = {24'hF0C7A1 ^ 24'($urandom_range(1, 24'hFFFFFF)), 8'(len)};
      pay.delete();
      for (int i = 0; i < len; i++)
        pay.push_back(($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom));
      send_frame(hdr, ($urandom_range(0, 5) == 0), 3);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    rdy_fixed = 1'b1;
    drain("rand");
    chk("rand_frames_ok", frames_ok, 16'(m_ok));
    chk("rand_frames_bad", frames_bad, 16'(m_bad));
    chk("rand_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
